// File: rtl/i2c_master_wr.sv
// Autonomous single-byte I2C write master: START, {SLV_ADDR,W}, ACK, data byte, ACK, STOP, then a bus-free gap.
// SCL is push-pull; SDA is open-drain (drives 0 or releases).
module i2c_master_wr #(
    parameter int         CLK_HZ   = 100_000_000,
    parameter int         SCL_HZ   = 100_000,
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         IDLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] mst_dfifo,
    output logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       ack_err
);
    localparam int QTR     = CLK_HZ / (4 * SCL_HZ);
    localparam int CNT_MAX = (IDLE_CYC > QTR) ? IDLE_CYC : QTR;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_CYC - 1);

    typedef enum logic [2:0] {GAP, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic          nack_q, nack_d;
    logic          busy_q, busy_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    shift_q, shift_d;
    logic          sda_s_q;
    logic          qtick;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= GAP;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    // Released SDA reads back as 1 through the external pull-up.
    always_ff @(posedge clk) begin
        byte_q  <= byte_d;
        shift_q <= shift_d;
        sda_s_q <= sda;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        qtick     = (cnt_q == QTR_LAST);
        if (state_q == GAP) begin
            if (cnt_q == GAP_LAST) begin
                state_d = START;
                cnt_d   = '0;
                qtr_d   = 2'd0;
                busy_d  = 1'b1;
                byte_d  = mst_dfifo;
                shift_d = {SLV_ADDR, 1'b0};
            end
        end else if (qtick) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                START: begin
                    if (qtr_q == 2'd1) begin
                        state_d = ADDR;
                        qtr_d   = 2'd0;
                        bit_d   = 3'd0;
                    end
                end
                ADDR, DATA: begin
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == ADDR) ? ACK1 : ACK2;
                        end
                    end
                end
                ACK1, ACK2: begin
                    // Leaving q2 the synchronised SDA reflects the bus while SCL is high.
                    if (qtr_q == 2'd2) begin
                        nack_d = nack_q | sda_s_q;
                    end
                    if (qtr_q == 2'd3) begin
                        if (state_q == ACK2 || nack_q) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                            shift_d = byte_q;
                        end
                    end
                end
                STOP: begin
                    if (qtr_q == 2'd1) begin
                        state_d   = GAP;
                        qtr_d     = 2'd0;
                        busy_d    = 1'b0;
                        ack_err_d = nack_q;
                        nack_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_d)
            START: sda_low_d = (qtr_d == 2'd1);
            ADDR, DATA: begin
                scl_d     = qtr_d[1];
                sda_low_d = ~shift_d[7];
            end
            ACK1, ACK2: scl_d = qtr_d[1];
            STOP: begin
                scl_d     = qtr_d[0];
                sda_low_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign scl     = scl_q;
    assign sda     = sda_low_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Directed bench for i2c_master_wr: bus monitor with an ACK-configurable slave and a START/STOP placement checker.
module tb_i2c_master_wr;
    localparam int CLK_HZ   = 4_000_000;
    localparam int SCL_HZ   = 100_000;
    localparam int IDLE_CYC = 40;
    localparam int QTR      = CLK_HZ / (4 * SCL_HZ);
    localparam int FULL_LEN = 76 * QTR;
    localparam int NACK_LEN = 40 * QTR;
    localparam int START_AT = IDLE_CYC + QTR + 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] mst_dfifo = 8'h00;
    logic       scl, busy, ack_err;
    wire        sda_bus;
    logic       slave_low = 1'b0;
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;

    assign sda_bus = slave_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_master_wr #(
        .CLK_HZ  (CLK_HZ),
        .SCL_HZ  (SCL_HZ),
        .SLV_ADDR(7'h50),
        .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mst_dfifo(mst_dfifo),
        .scl      (scl),
        .sda      (sda_bus),
        .busy     (busy),
        .ack_err  (ack_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor state
    int         cyc = 0, frames = 0, viol = 0, bitcnt = 0, bytecnt = 0, brun = 0;
    int         last_busy_len = 0, last_gap = 0, last_stop_cyc = 0;
    int         last_start_cyc = 0, prev_start_cyc = 0, last_nbytes = 0;
    logic       in_frame = 1'b0, m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;
    logic [7:0] sh = 8'h00, fb0 = 8'h00, fb1 = 8'h00, last_b0 = 8'h00, last_b1 = 8'h00;
    logic       fa0 = 1'b1, fa1 = 1'b1, last_a0 = 1'b1, last_a1 = 1'b1;

    always @(negedge clk) begin
        logic s_sda;
        s_sda = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
        cyc++;
        if (!rstn) begin
            in_frame  = 1'b0;
            bitcnt    = 0;
            bytecnt   = 0;
            brun      = 0;
            slave_low = 1'b0;
        end else begin
            if (busy) brun++;
            if (!m_busy && busy) last_gap = cyc - last_stop_cyc;
            if (m_busy && !busy) begin
                last_busy_len = brun;
                brun = 0;
            end
            if (m_scl && scl && (m_sda != s_sda)) begin
                if (!s_sda) begin
                    if (in_frame) viol++;
                    in_frame = 1'b1;
                    bitcnt = 0;
                    bytecnt = 0;
                    prev_start_cyc = last_start_cyc;
                    last_start_cyc = cyc;
                end else begin
                    // The STOP's own SCL pulse has been counted as one bit of a byte that never comes.
                    if (!in_frame || bitcnt != 1 || bytecnt == 0) begin
                        viol++;
                    end else begin
                        last_nbytes = bytecnt;
                        last_b0 = fb0;
                        last_a0 = fa0;
                        last_b1 = fb1;
                        last_a1 = fa1;
                        last_stop_cyc = cyc;
                        frames++;
                    end
                    in_frame = 1'b0;
                end
            end else if (!m_scl && scl && in_frame) begin
                if (bitcnt < 8) begin
                    sh = {sh[6:0], s_sda};
                    bitcnt++;
                end else begin
                    if (bytecnt == 0) begin
                        fb0 = sh;
                        fa0 = s_sda;
                    end else if (bytecnt == 1) begin
                        fb1 = sh;
                        fa1 = s_sda;
                    end
                    bytecnt++;
                    bitcnt = 0;
                end
            end else if (m_scl && !scl && in_frame) begin
                slave_low = (bitcnt == 8) && ((bytecnt == 0) ? ack_addr : ack_data);
            end
        end
        m_scl  = scl;
        m_sda  = s_sda;
        m_busy = busy;
    end

    task automatic wait_frames(input int target, input string tag);
        int k = 0;
        while (frames < target && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(frames), 32'(target));
    endtask

    task automatic wait_bit(input int byte_i, input int bit_i, input string tag);
        int k = 0;
        while (!(bytecnt == byte_i && bitcnt == bit_i && scl == 1'b0) && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(bytecnt == byte_i && bitcnt == bit_i && scl == 1'b0), 32'd1);
    endtask

    task automatic time_first_start(input string tag);
        int n = 1;
        while (sda_bus !== 1'b0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n), 32'(START_AT));
        chk({tag, "_scl"}, 32'(scl), 32'd1);
    endtask

    initial begin
        mst_dfifo = 8'h5A;
        ack_addr  = 1'b1;
        ack_data  = 1'b1;
        rstn      = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);

        rstn = 1'b1;
        time_first_start("first_start");

        // Fully acknowledged frame
        wait_frames(1, "f1_done");
        chk("f1_nbytes", 32'(last_nbytes), 32'd2);
        chk("f1_addr", 32'(last_b0), 32'hA0);
        chk("f1_addr_ack", 32'(last_a0), 32'd0);
        chk("f1_data", 32'(last_b1), 32'h5A);
        chk("f1_data_ack", 32'(last_a1), 32'd0);
        chk("f1_busy_len", 32'(last_busy_len), 32'(FULL_LEN));
        chk("f1_ack_err", 32'(ack_err), 32'd0);

        // No slave: address NACK
        ack_addr = 1'b0;
        wait_frames(2, "f2_done");
        chk("f2_nbytes", 32'(last_nbytes), 32'd1);
        chk("f2_addr", 32'(last_b0), 32'hA0);
        chk("f2_addr_ack", 32'(last_a0), 32'd1);
        chk("f2_busy_len", 32'(last_busy_len), 32'(NACK_LEN));
        chk("f2_ack_err", 32'(ack_err), 32'd1);
        chk("f2_gap", 32'(last_gap), 32'(IDLE_CYC));

        // Address ACKed, data NACKed
        ack_addr  = 1'b1;
        ack_data  = 1'b0;
        mst_dfifo = 8'h3C;
        wait_frames(3, "f3_done");
        chk("f3_nbytes", 32'(last_nbytes), 32'd2);
        chk("f3_addr_ack", 32'(last_a0), 32'd0);
        chk("f3_data", 32'(last_b1), 32'h3C);
        chk("f3_data_ack", 32'(last_a1), 32'd1);
        chk("f3_busy_len", 32'(last_busy_len), 32'(FULL_LEN));
        chk("f3_ack_err", 32'(ack_err), 32'd1);
        chk("f3_gap_after_nack", 32'(last_gap), 32'(IDLE_CYC));

        // Byte source changes mid-DATA; latched byte must win
        ack_data  = 1'b1;
        mst_dfifo = 8'h5A;
        wait_bit(1, 2, "f4_mid_data");
        mst_dfifo = 8'hC3;
        wait_frames(4, "f4_done");
        chk("f4_data", 32'(last_b1), 32'h5A);
        chk("f4_data_ack", 32'(last_a1), 32'd0);
        chk("f4_ack_err_clear", 32'(ack_err), 32'd0);
        wait_frames(5, "f5_done");
        chk("f5_data", 32'(last_b1), 32'hC3);
        chk("f5_period", 32'(last_start_cyc - prev_start_cyc), 32'(FULL_LEN + IDLE_CYC));

        // Reset during DATA bit 3 (a 0 bit of 0xC3)
        wait_bit(1, 3, "f6_data_bit3");
        chk("f6_pre_rst_sda", 32'(sda_bus), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda", 32'(sda_bus), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_hold_scl", 32'(scl), 32'd1);
        rstn = 1'b1;
        time_first_start("restart_start");
        wait_frames(6, "f7_done");
        chk("f7_addr", 32'(last_b0), 32'hA0);
        chk("f7_data", 32'(last_b1), 32'hC3);
        chk("f7_data_ack", 32'(last_a1), 32'd0);
        chk("f7_ack_err", 32'(ack_err), 32'd0);
        chk("bus_violations", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
